// File: rtl/dio_pulse_seq.sv
// rtl/dio_pulse_seq.sv - Triggered multi-channel delay/width pulse sequencer with interlock
//
// Purpose:
//   Accepts a beam trigger (asynchronous, synchronised and edge-detected) or a
//   software strobe. Each accepted trigger drives a fixed-width o_do_trg pulse
//   and starts an independent delay/width pulse on every idle channel that is
//   in pulse mode. A sticky interlock forces every output inactive and blocks
//   triggers until it is cleared.
//
// Ports:
//   s00_axi_aclk     clock
//   s00_axi_aresetn  asynchronous active-low reset
//   i_beam_trg       beam trigger, asynchronous
//   i_sw_trg         software trigger strobe, synchronous
//   i_enable         global trigger enable
//   i_mode           per channel: 0 = manual level, 1 = triggered pulse
//   i_polarity       per channel: 1 = active-low output
//   i_manual         per channel manual level
//   i_delay          per channel delay, CNT_WIDTH bits per channel
//   i_width          per channel width, CNT_WIDTH bits per channel
//   i_interlock      interlock request, asynchronous
//   i_intl_clr       interlock clear strobe
//   o_do_trg         trigger output pulse
//   o_do_ch          channel outputs
//   o_do_interlock   sticky interlock flag
//   o_busy           any channel sequencing or o_do_trg high
//   o_trg_cnt        accepted trigger count
//   o_led            toggles on each accepted trigger

module dio_pulse_seq #(
    parameter int CH_NUM      = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int TRG_WIDTH   = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    input  logic                          i_beam_trg,
    input  logic                          i_sw_trg,
    input  logic                          i_enable,
    input  logic [CH_NUM-1:0]             i_mode,
    input  logic [CH_NUM-1:0]             i_polarity,
    input  logic [CH_NUM-1:0]             i_manual,
    input  logic [CH_NUM*CNT_WIDTH-1:0]   i_delay,
    input  logic [CH_NUM*CNT_WIDTH-1:0]   i_width,
    input  logic                          i_interlock,
    input  logic                          i_intl_clr,
    output logic                          o_do_trg,
    output logic [CH_NUM-1:0]             o_do_ch,
    output logic                          o_do_interlock,
    output logic                          o_busy,
    output logic [31:0]                   o_trg_cnt,
    output logic                          o_led
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;

    localparam int TW = (TRG_WIDTH > 1) ? $clog2(TRG_WIDTH) : 1;

    logic [SYNC_STAGES-1:0] r_beam_sync;
    logic [SYNC_STAGES-1:0] r_intl_sync;
    logic                   r_beam_prev;
    logic                   r_intl;
    logic                   r_do_trg;
    logic [TW-1:0]          r_tcnt;
    logic [31:0]            r_trg_cnt;
    logic                   r_led;

    logic                   w_beam_edge;
    logic                   w_intl_sync;
    logic                   w_force;
    logic                   w_trig;
    logic [CH_NUM-1:0]      w_ch_busy;

    assign w_beam_edge = r_beam_sync[SYNC_STAGES-1] & ~r_beam_prev;
    assign w_intl_sync = r_intl_sync[SYNC_STAGES-1];
    // Outputs go inactive on the same edge the flag sets, not one clock later.
    assign w_force     = w_intl_sync | r_intl;
    assign w_trig      = (w_beam_edge | i_sw_trg) & i_enable & ~r_intl & ~r_do_trg;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_beam_sync <= '0;
            r_intl_sync <= '0;
            r_beam_prev <= 1'b0;
            r_intl      <= 1'b0;
        end else begin
            r_beam_sync <= {r_beam_sync[SYNC_STAGES-2:0], i_beam_trg};
            r_intl_sync <= {r_intl_sync[SYNC_STAGES-2:0], i_interlock};
            r_beam_prev <= r_beam_sync[SYNC_STAGES-1];
            // A live interlock request overrides a coincident clear.
            r_intl      <= w_intl_sync | (r_intl & ~i_intl_clr);
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_do_trg  <= 1'b0;
            r_tcnt    <= '0;
            r_trg_cnt <= '0;
            r_led     <= 1'b0;
        end else begin
            if (w_force) begin
                r_do_trg <= 1'b0;
                r_tcnt   <= '0;
            end else if (w_trig) begin
                r_do_trg <= 1'b1;
                r_tcnt   <= TW'(TRG_WIDTH - 1);
            end else if (r_do_trg) begin
                if (r_tcnt == '0) begin
                    r_do_trg <= 1'b0;
                end else begin
                    r_tcnt <= r_tcnt - 1'b1;
                end
            end
            if (w_trig) begin
                r_trg_cnt <= r_trg_cnt + 32'd1;
                r_led     <= ~r_led;
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < CH_NUM; k++) begin : g_ch
            logic [1:0]           r_state;
            logic [CNT_WIDTH-1:0] r_cnt;
            logic [CNT_WIDTH-1:0] r_wid;
            logic                 r_out;
            logic [1:0]           w_nxt_state;
            logic [CNT_WIDTH-1:0] w_nxt_cnt;
            logic [CNT_WIDTH-1:0] w_nxt_wid;
            logic [CNT_WIDTH-1:0] w_d;
            logic [CNT_WIDTH-1:0] w_w;
            logic                 w_active;

            assign w_d = i_delay[k*CNT_WIDTH +: CNT_WIDTH];
            assign w_w = i_width[k*CNT_WIDTH +: CNT_WIDTH];

            // Counters hold "cycles remaining minus one" so the full
            // CNT_WIDTH range is usable without an extra bit.
            always_comb begin
                w_nxt_state = r_state;
                w_nxt_cnt   = r_cnt;
                w_nxt_wid   = r_wid;
                if (w_force || !i_mode[k]) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (w_trig) begin
                                w_nxt_wid = w_w;
                                if (w_d != '0) begin
                                    w_nxt_state = ST_DELAY;
                                    w_nxt_cnt   = w_d - 1'b1;
                                end else if (w_w != '0) begin
                                    w_nxt_state = ST_PULSE;
                                    w_nxt_cnt   = w_w - 1'b1;
                                end
                            end
                        end
                        ST_DELAY: begin
                            if (r_cnt == '0) begin
                                if (r_wid != '0) begin
                                    w_nxt_state = ST_PULSE;
                                    w_nxt_cnt   = r_wid - 1'b1;
                                end else begin
                                    w_nxt_state = ST_IDLE;
                                end
                            end else begin
                                w_nxt_cnt = r_cnt - 1'b1;
                            end
                        end
                        ST_PULSE: begin
                            if (r_cnt == '0) begin
                                w_nxt_state = ST_IDLE;
                            end else begin
                                w_nxt_cnt = r_cnt - 1'b1;
                            end
                        end
                        default: begin
                            w_nxt_state = ST_IDLE;
                            w_nxt_cnt   = '0;
                        end
                    endcase
                end
            end

            // The output register tracks the next state so the pin is
            // active exactly while the FSM sits in PULSE.
            always_comb begin
                w_active = 1'b0;
                if (w_force) begin
                    w_active = 1'b0;
                end else if (!i_mode[k]) begin
                    w_active = i_manual[k];
                end else begin
                    w_active = (w_nxt_state == ST_PULSE);
                end
            end

            always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
                if (!s00_axi_aresetn) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_wid   <= '0;
                    r_out   <= 1'b0;
                end else begin
                    r_state <= w_nxt_state;
                    r_cnt   <= w_nxt_cnt;
                    r_wid   <= w_nxt_wid;
                    r_out   <= w_active ^ i_polarity[k];
                end
            end

            assign w_ch_busy[k] = (r_state != ST_IDLE);
            assign o_do_ch[k]   = r_out;
        end
    endgenerate

    assign o_do_trg       = r_do_trg;
    assign o_do_interlock = r_intl;
    assign o_busy         = (|w_ch_busy) | r_do_trg;
    assign o_trg_cnt      = r_trg_cnt;
    assign o_led          = r_led;

endmodule

// File: tb/tb_dio_pulse_seq.sv
// tb/tb_dio_pulse_seq.sv - Self-checking bench for dio_pulse_seq
module tb_dio_pulse_seq;

    localparam int CH = 4;
    localparam int CW = 16;
    localparam int TW = 20;
    localparam int SS = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             beam;
    logic             sw;
    logic             en;
    logic [CH-1:0]    mode;
    logic [CH-1:0]    pol;
    logic [CH-1:0]    man;
    logic [CH*CW-1:0] dly;
    logic [CH*CW-1:0] wid;
    logic             intl;
    logic             clr;
    logic             do_trg;
    logic [CH-1:0]    do_ch;
    logic             do_intl;
    logic             busy;
    logic [31:0]      trg_cnt;
    logic             led;

    int n_vec = 0;
    int n_err = 0;

    dio_pulse_seq #(.CH_NUM(CH), .CNT_WIDTH(CW), .TRG_WIDTH(TW), .SYNC_STAGES(SS)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .i_beam_trg(beam), .i_sw_trg(sw),
        .i_enable(en), .i_mode(mode), .i_polarity(pol), .i_manual(man), .i_delay(dly),
        .i_width(wid), .i_interlock(intl), .i_intl_clr(clr), .o_do_trg(do_trg),
        .o_do_ch(do_ch), .o_do_interlock(do_intl), .o_busy(busy), .o_trg_cnt(trg_cnt),
        .o_led(led)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input int d, input int w);
        dly[k*CW +: CW] = CW'(d);
        wid[k*CW +: CW] = CW'(w);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; beam = 0; sw = 0; en = 0; mode = '0; pol = '0; man = '0;
        dly = '0; wid = '0; intl = 0; clr = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; beam = 0; sw = 0; en = 1; mode = '1; pol = '1; man = '1;
        dly = '0; wid = '0; intl = 0; clr = 0;
        tick();
        n_vec++; if (do_trg !== 1'b0) begin n_err++; $display("FAIL reset_trg: got %b exp 0", do_trg); end
        n_vec++; if (do_ch !== 4'h0) begin n_err++; $display("FAIL reset_ch: got %h exp 0", do_ch); end
        n_vec++; if (do_intl !== 1'b0) begin n_err++; $display("FAIL reset_intl: got %b exp 0", do_intl); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_vec++; if (trg_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %h exp 0", trg_cnt); end
        n_vec++; if (led !== 1'b0) begin n_err++; $display("FAIL reset_led: got %b exp 0", led); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        en = 1; mode = 4'b0001; set_ch(0, 10, 5);
        sw = 1; tick(); sw = 0;
        for (int t = 1; t <= 25; t++) begin
            n_vec++;
            if (do_ch[0] !== (t >= 11 && t <= 15)) begin
                n_err++; $display("FAIL basic_ch0 t=%0d: got %b exp %b", t, do_ch[0], (t >= 11 && t <= 15));
            end
            n_vec++;
            if (do_trg !== (t <= TW)) begin
                n_err++; $display("FAIL basic_trg t=%0d: got %b exp %b", t, do_trg, (t <= TW));
            end
            tick();
        end
        n_vec++; if (trg_cnt !== 32'd1) begin n_err++; $display("FAIL basic_cnt: got %0d exp 1", trg_cnt); end
        n_vec++; if (led !== 1'b1) begin n_err++; $display("FAIL basic_led: got %b exp 1", led); end
    endtask

    task automatic test_beam();
        int waited;
        do_reset();
        en = 1; mode = 4'b0110; set_ch(1, 0, 1); set_ch(2, 3, 0);
        @(posedge clk); #3 beam = 1;
        waited = 0;
        while (do_trg !== 1'b1 && waited < 10) begin tick(); waited++; end
        n_vec++;
        if (waited != SS + 1) begin n_err++; $display("FAIL beam_latency: got %0d exp %0d", waited, SS + 1); end
        for (int t = 1; t <= 25; t++) begin
            n_vec++;
            if (do_ch[1] !== (t == 1)) begin n_err++; $display("FAIL beam_ch1 t=%0d: got %b exp %b", t, do_ch[1], (t == 1)); end
            n_vec++;
            if (do_ch[2] !== 1'b0) begin n_err++; $display("FAIL beam_ch2 t=%0d: got %b exp 0", t, do_ch[2]); end
            n_vec++;
            if (busy !== (t <= TW)) begin n_err++; $display("FAIL beam_busy t=%0d: got %b exp %b", t, busy, (t <= TW)); end
            tick();
        end
        beam = 0;
        n_vec++; if (trg_cnt !== 32'd1) begin n_err++; $display("FAIL beam_cnt: got %0d exp 1", trg_cnt); end
    endtask

    task automatic test_retrigger();
        int highs;
        int first;
        do_reset();
        en = 1; mode = 4'b0001; set_ch(0, 10, 100);
        sw = 1; tick(); sw = 0;
        highs = 0; first = -1;
        for (int t = 1; t <= 130; t++) begin
            sw = (t == 5);
            if (do_ch[0] === 1'b1) begin highs++; if (first < 0) first = t; end
            n_vec++;
            if (do_trg !== (t <= TW)) begin n_err++; $display("FAIL retrig_trg t=%0d: got %b exp %b", t, do_trg, (t <= TW)); end
            tick();
        end
        sw = 0;
        n_vec++; if (highs != 100) begin n_err++; $display("FAIL retrig_width: got %0d exp 100", highs); end
        n_vec++; if (first != 11) begin n_err++; $display("FAIL retrig_start: got %0d exp 11", first); end
        n_vec++; if (trg_cnt !== 32'd1) begin n_err++; $display("FAIL retrig_cnt: got %0d exp 1", trg_cnt); end
    endtask

    task automatic test_manual_intl();
        int waited;
        do_reset();
        en = 1; pol = 4'b0101; mode = 4'b0000; man = 4'b0011;
        tick();
        n_vec++; if (do_ch !== 4'b0110) begin n_err++; $display("FAIL manual_out: got %b exp 0110", do_ch); end
        intl = 1;
        waited = 0;
        while (do_intl !== 1'b1 && waited < SS + 1) begin tick(); waited++; end
        n_vec++; if (do_intl !== 1'b1) begin n_err++; $display("FAIL intl_flag: got %b exp 1", do_intl); end
        n_vec++; if (do_ch !== 4'b0101) begin n_err++; $display("FAIL intl_ch: got %b exp 0101", do_ch); end
        sw = 1; tick(); sw = 0; tick();
        n_vec++; if (trg_cnt !== 32'd0) begin n_err++; $display("FAIL intl_reject_cnt: got %0d exp 0", trg_cnt); end
        n_vec++; if (do_trg !== 1'b0) begin n_err++; $display("FAIL intl_reject_trg: got %b exp 0", do_trg); end
        intl = 0;
    endtask

    task automatic test_intl_clear();
        int waited;
        do_reset();
        en = 1; mode = 4'b0001; set_ch(0, 2, 50);
        sw = 1; tick(); sw = 0;
        repeat (5) tick();
        n_vec++; if (do_ch[0] !== 1'b1) begin n_err++; $display("FAIL clr_prepulse: got %b exp 1", do_ch[0]); end
        intl = 1;
        waited = 0;
        while (do_intl !== 1'b1 && waited < SS + 1) begin tick(); waited++; end
        n_vec++; if (do_intl !== 1'b1) begin n_err++; $display("FAIL clr_flag_set: got %b exp 1", do_intl); end
        n_vec++; if (do_ch[0] !== 1'b0) begin n_err++; $display("FAIL clr_forced_ch: got %b exp 0", do_ch[0]); end
        n_vec++; if (do_trg !== 1'b0) begin n_err++; $display("FAIL clr_forced_trg: got %b exp 0", do_trg); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_forced_busy: got %b exp 0", busy); end
        clr = 1; tick(); clr = 0;
        n_vec++; if (do_intl !== 1'b1) begin n_err++; $display("FAIL clr_while_high: got %b exp 1", do_intl); end
        intl = 0;
        repeat (SS + 1) tick();
        clr = 1; tick(); clr = 0;
        n_vec++; if (do_intl !== 1'b0) begin n_err++; $display("FAIL clr_flag_clear: got %b exp 0", do_intl); end
        n_vec++; if (do_ch[0] !== 1'b0) begin n_err++; $display("FAIL clr_no_resume: got %b exp 0", do_ch[0]); end
        sw = 1; tick(); sw = 0;
        n_vec++; if (do_trg !== 1'b1) begin n_err++; $display("FAIL clr_retrig_trg: got %b exp 1", do_trg); end
        n_vec++; if (trg_cnt !== 32'd2) begin n_err++; $display("FAIL clr_retrig_cnt: got %0d exp 2", trg_cnt); end
        tick(); tick();
        n_vec++; if (do_ch[0] !== 1'b1) begin n_err++; $display("FAIL clr_retrig_ch: got %b exp 1", do_ch[0]); end
    endtask

    // Reference model: each accepted trigger at cycle T opens a window
    // [T+1+D, T+D+W] on every channel that was idle; a channel stays busy
    // through T+D+W.
    task automatic test_random();
        int cs[CH];
        int cd[CH];
        int cw[CH];
        int cur_d[CH];
        int cur_w[CH];
        int tT;
        logic [31:0] e_cnt;
        logic e_led;
        logic e_trg;
        logic e_busy;
        logic [CH-1:0] e_ch;
        logic on;
        do_reset();
        en = 1; mode = '1; pol = CH'($urandom);
        tT = -1000; e_cnt = 0; e_led = 0;
        for (int k = 0; k < CH; k++) begin
            cs[k] = -1000; cd[k] = 0; cw[k] = 0;
            cur_d[k] = $urandom_range(0, 12); cur_w[k] = $urandom_range(0, 12);
            set_ch(k, cur_d[k], cur_w[k]);
        end
        tick();
        for (int c = 0; c < 400; c++) begin
            e_trg = (c >= tT + 1) && (c <= tT + TW);
            e_busy = e_trg;
            for (int k = 0; k < CH; k++) begin
                on = (c >= cs[k] + 1 + cd[k]) && (c <= cs[k] + cd[k] + cw[k]);
                e_ch[k] = on ^ pol[k];
                if (c >= cs[k] + 1 && c <= cs[k] + cd[k] + cw[k]) e_busy = 1'b1;
            end
            n_vec++; if (do_ch !== e_ch) begin n_err++; $display("FAIL rand_ch c=%0d: got %b exp %b", c, do_ch, e_ch); end
            n_vec++; if (do_trg !== e_trg) begin n_err++; $display("FAIL rand_trg c=%0d: got %b exp %b", c, do_trg, e_trg); end
            n_vec++; if (busy !== e_busy) begin n_err++; $display("FAIL rand_busy c=%0d: got %b exp %b", c, busy, e_busy); end
            n_vec++; if (trg_cnt !== e_cnt) begin n_err++; $display("FAIL rand_cnt c=%0d: got %0d exp %0d", c, trg_cnt, e_cnt); end
            n_vec++; if (led !== e_led) begin n_err++; $display("FAIL rand_led c=%0d: got %b exp %b", c, led, e_led); end
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    cur_d[k] = $urandom_range(0, 12); cur_w[k] = $urandom_range(0, 12);
                    set_ch(k, cur_d[k], cur_w[k]);
                end
            end
            en = ($urandom_range(0, 7) != 0);
            sw = ($urandom_range(0, 5) == 0);
            if (sw && en && !e_trg) begin
                e_cnt = e_cnt + 1; e_led = ~e_led; tT = c;
                for (int k = 0; k < CH; k++) begin
                    if (c > cs[k] + cd[k] + cw[k]) begin
                        cs[k] = c; cd[k] = cur_d[k]; cw[k] = cur_w[k];
                    end
                end
            end
            tick();
        end
        sw = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        en = 1;
        force dut.r_trg_cnt = 32'hFFFF_FFFE;
        tick();
        release dut.r_trg_cnt;
        sw = 1; tick(); sw = 0;
        n_vec++; if (trg_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_max: got %h exp ffffffff", trg_cnt); end
        repeat (TW + 1) tick();
        sw = 1; tick(); sw = 0;
        n_vec++; if (trg_cnt !== 32'h0) begin n_err++; $display("FAIL wrap_zero: got %h exp 0", trg_cnt); end
        n_vec++; if (led !== 1'b0) begin n_err++; $display("FAIL wrap_led: got %b exp 0", led); end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        en = 1; mode = 4'b0001; set_ch(0, 50, 5);
        sw = 1; tick(); sw = 0;
        repeat (4) tick();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b exp 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (do_trg !== 1'b0) begin n_err++; $display("FAIL rstmid_trg: got %b exp 0", do_trg); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
        n_vec++; if (trg_cnt !== 32'd0) begin n_err++; $display("FAIL rstmid_cnt: got %0d exp 0", trg_cnt); end
        n_vec++; if (led !== 1'b0) begin n_err++; $display("FAIL rstmid_led: got %b exp 0", led); end
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int t = 0; t < 70; t++) begin
            tick();
            if (do_ch[0] !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL rstmid_resume: got %0d active cycles exp 0", bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_beam();
        test_retrigger();
        test_manual_intl();
        test_intl_clear();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dio_pulse_seq.md
Name: dio_pulse_seq

Overview:
- Parametrised digital-output sequencer for the TRBDS3 DIO path; generalises the fixed 4-channel register-driven outputs.
- Triggers come from the beam trigger input or a software strobe. It generates a trigger output pulse and CH_NUM independently delayed, width-programmed pulse channels.
- Includes a sticky interlock that forces all outputs inactive. Register values arrive as flat parallel buses from the S00_AXI register file.

Parameters:
- CH_NUM, 4, number of pulse channels (1..16).
- CNT_WIDTH, 16, width of the per-channel delay and width counters.
- TRG_WIDTH, 20, o_do_trg high time in clocks (100 ns at 200 MHz), ≥1.
- SYNC_STAGES, 2, synchroniser depth for i_beam_trg and i_interlock, ≥2.

Ports:
- s00_axi_aclk  in  1  system clock, 200 MHz.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- i_beam_trg  in  1  external beam trigger, asynchronous.
- i_sw_trg  in  1  software trigger, one-clock strobe, synchronous.
- i_enable  in  1  global trigger enable.
- i_mode  in  CH_NUM  per channel: 0 = manual level, 1 = triggered pulse.
- i_polarity  in  CH_NUM  per channel: 1 = active-low output.
- i_manual  in  CH_NUM  manual level, used when i_mode = 0.
- i_delay  in  CH_NUM*CNT_WIDTH  per-channel delay in clocks; channel k occupies bits [k*CNT_WIDTH +: CNT_WIDTH].
- i_width  in  CH_NUM*CNT_WIDTH  per-channel pulse width in clocks, same packing as i_delay.
- i_interlock  in  1  external interlock request, asynchronous.
- i_intl_clr  in  1  interlock clear strobe, synchronous.
- o_do_trg  out  1  trigger output pulse.
- o_do_ch  out  CH_NUM  channel outputs.
- o_do_interlock  out  1  sticky interlock status/output.
- o_busy  out  1  OR of all channels not IDLE, plus o_do_trg.
- o_trg_cnt  out  32  accepted trigger count.
- o_led  out  1  toggles on each accepted trigger.

Behaviour:
- Reset (async assert, sync release): all outputs 0, all channel FSMs IDLE, counters 0, interlock flag clear, synchroniser chains 0.
- i_beam_trg passes through SYNC_STAGES flops, then a rising-edge detector (one registered flop).
- Raw event = beam edge OR i_sw_trg; coincident sources count as one event.
- Accepted trigger (cycle T) = raw event AND i_enable AND NOT interlock flag AND NOT o_do_trg. Events that are not accepted are dropped silently.
- On an accepted trigger:
  - o_trg_cnt increments; it wraps from 0xFFFFFFFF to 0.
  - o_led toggles.
  - o_do_trg goes high T+1 to T+TRG_WIDTH inclusive.
- Channel FSM in pulse mode (i_mode[k] = 1):
  - States: IDLE, DELAY, PULSE.
  - IDLE -> DELAY on accepted trigger, with delay and width values captured at T. Later register changes do not affect a running sequence.
  - Active level is output from cycle T+1+D through T+D+W inclusive (D = delay, W = width). D = 0 means active from T+1.
  - W = 0: no pulse; return to IDLE at T+1+D.
  - PULSE -> IDLE when the width counter expires.
  - A trigger arriving while the channel is not IDLE is ignored by that channel; channels are independent.
- Manual mode (i_mode[k] = 0): channel FSM held IDLE; active level = i_manual[k], registered, one-clock latency.
- Switching mode mid-sequence aborts the sequence, returns the channel to IDLE and takes the manual level the next clock.
- Output stage: o_do_ch[k] = active[k] XOR i_polarity[k], registered. Inactive level = i_polarity[k].
- Interlock:
  - Synchronised i_interlock high sets the flag in the next clock.
  - o_do_interlock = flag.
  - While the flag is set: all channels forced IDLE, o_do_ch = i_polarity (inactive), o_do_trg forced 0 immediately (counter cleared), triggers rejected.
  - Flag clears on i_intl_clr only when synchronised i_interlock is low. If both are high in the same cycle, the interlock wins and the flag stays set.
- Reset asserted mid-sequence: all outputs drop to 0 asynchronously; no sequence resumes after release.
- Counter arithmetic is unsigned CNT_WIDTH; D = W = 2^CNT_WIDTH-1 is legal with no overflow.

Test Plan:
- Reset, i_enable = 1, ch0 pulse mode, D = 10, W = 5, sw trigger at cycle T -> o_do_ch[0] high T+11..T+15; o_do_trg high T+1..T+20; o_trg_cnt = 1; o_led = 1.
- Beam trigger async edge, ch1 D = 0, W = 1, ch2 W = 0 -> ch1 high exactly one clock, 1 clock after the edge-detect strobe; ch2 never asserts; o_busy falls after o_do_trg ends.
- Retrigger at T+5 with ch0 D = 10, W = 100 -> second trigger rejected (o_do_trg still high); o_trg_cnt = 1; single 100-clock pulse.
- i_polarity = 4'b0101, manual i_manual = 4'b0011 -> o_do_ch = 4'b0110 one clock after; interlock raised -> o_do_ch = 4'b0101, o_do_interlock = 1 within SYNC_STAGES+1 clocks.
- Interlock mid-PULSE, then i_intl_clr while i_interlock still high -> flag stays set; drop i_interlock, then clr -> flag clears; next sw trigger is accepted normally.
- Counter wrap: preload via 2^32 triggers (or force) -> 0xFFFFFFFF then 0; async reset during DELAY -> all outputs 0 immediately, channel IDLE after release.
